// File: rtl/wfq_ingress_framer_pkg.sv
// Shared definitions for the WFQ ingress framer: header field offsets,
// FSM state encoding and the default arrival spacing.
package wfq_ingress_framer_pkg;

    localparam int FLOWID_LSB              = 0;
    localparam int LEN_LSB                 = 16;
    localparam int DEFAULT_MIN_ARRIVAL_GAP = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_PAD     = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

endpackage

// File: rtl/wfq_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module wfq_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wfq_ingress_framer.sv
// Ingress framer: parses packet headers, issues spaced arrival pulses and
// forwards exactly the declared number of words (padding or truncating).
module wfq_ingress_framer
    import wfq_ingress_framer_pkg::*;
#(
    parameter int PACKET_DATA_BITWIDTH = 64,
    parameter int PACKET_LEN_BITWIDTH  = 9,
    parameter int FLOWID_BITWIDTH      = 13,
    parameter int MIN_ARRIVAL_GAP      = DEFAULT_MIN_ARRIVAL_GAP,
    parameter int CNT_BITWIDTH         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sop,
    input  logic                            in_eop,
    input  logic [PACKET_DATA_BITWIDTH-1:0] in_data,
    output logic                            out_packet_arrival,
    output logic [PACKET_LEN_BITWIDTH-1:0]  out_packet_length,
    output logic [FLOWID_BITWIDTH-1:0]      out_flow_id,
    output logic                            out_data_arrival,
    output logic [PACKET_DATA_BITWIDTH-1:0] out_packet_data,
    output logic [CNT_BITWIDTH-1:0]         out_pkt_cnt,
    output logic [CNT_BITWIDTH-1:0]         out_err_cnt
);

    localparam int GAP_W = (MIN_ARRIVAL_GAP > 2) ? $clog2(MIN_ARRIVAL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_ARRIVAL_GAP - 1);

    state_t                         state;
    state_t                         state_nxt;
    logic [PACKET_LEN_BITWIDTH-1:0] word_cnt;
    logic [GAP_W-1:0]               gap_cnt;

    logic                           accept;
    logic                           last_word;
    logic [PACKET_LEN_BITWIDTH-1:0] hdr_len;
    logic [FLOWID_BITWIDTH-1:0]     hdr_flow;

    logic hdr_take;
    logic fwd_word;
    logic pad_word;
    logic pkt_inc;
    logic err_inc;

    assign hdr_len  = in_data[LEN_LSB +: PACKET_LEN_BITWIDTH];
    assign hdr_flow = in_data[FLOWID_LSB +: FLOWID_BITWIDTH];

    assign in_ready = (state == ST_DATA) || (state == ST_DISCARD) ||
                      ((state == ST_IDLE) && (gap_cnt == '0));
    assign accept    = in_valid && in_ready;
    // out_packet_length doubles as the latched length of the current packet.
    assign last_word = ((word_cnt + 1'b1) == out_packet_length);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && in_sop && (hdr_len != '0)) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (accept) begin
                    if (in_eop && last_word)  state_nxt = ST_IDLE;
                    else if (in_eop)          state_nxt = ST_PAD;
                    else if (last_word)       state_nxt = ST_DISCARD;
                end
            end
            ST_PAD: begin
                if (last_word) state_nxt = ST_IDLE;
            end
            ST_DISCARD: begin
                if (accept && in_eop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_take = 1'b0;
        fwd_word = 1'b0;
        pad_word = 1'b0;
        pkt_inc  = 1'b0;
        err_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_sop && (hdr_len != '0)) hdr_take = 1'b1;
                    else                           err_inc  = 1'b1;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    fwd_word = 1'b1;
                    if (in_eop && last_word)              pkt_inc = 1'b1;
                    else if (in_eop || last_word)         err_inc = 1'b1;
                end
            end
            ST_PAD: begin
                pad_word = 1'b1;
                pkt_inc  = last_word;
            end
            ST_DISCARD: begin
                pkt_inc = accept && in_eop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_packet_arrival <= 1'b0;
            out_packet_length  <= '0;
            out_flow_id        <= '0;
            out_data_arrival   <= 1'b0;
            out_packet_data    <= '0;
            word_cnt           <= '0;
            gap_cnt            <= '0;
        end else begin
            out_packet_arrival <= hdr_take;
            out_data_arrival   <= fwd_word || pad_word;

            if (hdr_take) begin
                out_packet_length <= hdr_len;
                out_flow_id       <= hdr_flow;
                word_cnt          <= '0;
            end else if (fwd_word || pad_word) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (fwd_word)      out_packet_data <= in_data;
            else if (pad_word) out_packet_data <= '0;

            // Spacing timer runs in every state so it can expire during the packet.
            if (hdr_take)              gap_cnt <= GAP_RELOAD;
            else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;
        end
    end

    wfq_sat_counter #(.WIDTH(CNT_BITWIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pkt_inc),
        .count (out_pkt_cnt)
    );

    wfq_sat_counter #(.WIDTH(CNT_BITWIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (out_err_cnt)
    );

endmodule

// File: tb/tb_wfq_ingress_framer.sv
// Bench for wfq_ingress_framer: directed and random packets compared against
// a packet-level model of the expected arrivals, words and counters.
module tb_wfq_ingress_framer;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_packet_arrival;
    logic [8:0]  out_packet_length;
    logic [12:0] out_flow_id;
    logic        out_data_arrival;
    logic [63:0] out_packet_data;
    logic [15:0] out_pkt_cnt;
    logic [15:0] out_err_cnt;

    wfq_ingress_framer #(
        .PACKET_DATA_BITWIDTH (64),
        .PACKET_LEN_BITWIDTH  (9),
        .FLOWID_BITWIDTH      (13),
        .MIN_ARRIVAL_GAP      (GAP),
        .CNT_BITWIDTH         (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_sop             (in_sop),
        .in_eop             (in_eop),
        .in_data            (in_data),
        .out_packet_arrival (out_packet_arrival),
        .out_packet_length  (out_packet_length),
        .out_flow_id        (out_flow_id),
        .out_data_arrival   (out_data_arrival),
        .out_packet_data    (out_packet_data),
        .out_pkt_cnt        (out_pkt_cnt),
        .out_err_cnt        (out_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  len;
        logic [12:0] flow;
        int          cyc;
    } arr_t;

    typedef struct {
        logic [63:0] data;
        logic [8:0]  len;
        int          cyc;
    } dat_t;

    arr_t got_arr[$];
    arr_t exp_arr[$];
    dat_t got_dat[$];
    dat_t exp_dat[$];
    int   exp_pkt = 0;
    int   exp_err = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (rst) begin
            if (out_packet_arrival)
                got_arr.push_back('{out_packet_length, out_flow_id, cyc});
            if (out_data_arrival)
                got_dat.push_back('{out_packet_data, out_packet_length, cyc});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one word and holds it until the handshake; records the cycle
    // in which it was accepted (outputs for it appear one cycle later).
    task automatic send_word(input logic sop, input logic eop, input logic [63:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("handshake", 64'(in_ready), 64'd1);
        last_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    function automatic logic [63:0] make_hdr(input logic [12:0] flow, input logic [8:0] len);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[12:0]  = flow;
        h[24:16] = len;
        return h;
    endfunction

    // Packet-level model: the framer must deliver exactly len words, the
    // first min(nw,len) being the sent words and the rest zeros.
    task automatic send_pkt(input logic [12:0] flow, input logic [8:0] len,
                            input int nw, output int hdr_cyc);
        logic [63:0] d;
        int          n_len = int'(len);
        send_word(1'b1, 1'b0, make_hdr(flow, len));
        hdr_cyc = last_acc;
        if (len == 0) begin
            exp_err++;
            return;
        end
        exp_arr.push_back('{len, flow, hdr_cyc + 1});
        for (int i = 0; i < nw; i++) begin
            d = {$urandom, $urandom};
            send_word(1'($urandom_range(0, 1)), (i == nw - 1), d);
            if (i < n_len) exp_dat.push_back('{d, len, last_acc + 1});
        end
        if (nw < n_len) begin
            exp_err++;
            for (int k = 0; k < n_len - nw; k++)
                exp_dat.push_back('{64'd0, len, last_acc + 2 + k});
        end else if (nw > n_len) begin
            exp_err++;
        end
        exp_pkt++;
    endtask

    task automatic send_stray();
        send_word(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        exp_err++;
    endtask

    task automatic compare_all(input string tag);
        int n;
        idle(GAP + 8);
        chk({tag, "_arr_count"}, 64'(got_arr.size()), 64'(exp_arr.size()));
        chk({tag, "_dat_count"}, 64'(got_dat.size()), 64'(exp_dat.size()));
        n = (got_arr.size() < exp_arr.size()) ? got_arr.size() : exp_arr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_arr_len"},  64'(got_arr[i].len),  64'(exp_arr[i].len));
            chk({tag, "_arr_flow"}, 64'(got_arr[i].flow), 64'(exp_arr[i].flow));
            chk({tag, "_arr_cyc"},  64'(got_arr[i].cyc),  64'(exp_arr[i].cyc));
        end
        for (int i = 1; i < got_arr.size(); i++)
            chk({tag, "_arr_spacing_ok"}, 64'(got_arr[i].cyc - got_arr[i-1].cyc >= GAP), 64'd1);
        n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_dat_data"}, got_dat[i].data,      exp_dat[i].data);
            chk({tag, "_dat_len"},  64'(got_dat[i].len),  64'(exp_dat[i].len));
            chk({tag, "_dat_cyc"},  64'(got_dat[i].cyc),  64'(exp_dat[i].cyc));
        end
        chk({tag, "_pkt_cnt"}, 64'(out_pkt_cnt), 64'(exp_pkt));
        chk({tag, "_err_cnt"}, 64'(out_err_cnt), 64'(exp_err));
        got_arr.delete();
        exp_arr.delete();
        got_dat.delete();
        exp_dat.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_arrival"},  64'(out_packet_arrival), 64'd0);
        chk({tag, "_length"},   64'(out_packet_length),  64'd0);
        chk({tag, "_flow"},     64'(out_flow_id),        64'd0);
        chk({tag, "_data_arr"}, 64'(out_data_arrival),   64'd0);
        chk({tag, "_data"},     out_packet_data,         64'd0);
        chk({tag, "_pkt_cnt"},  64'(out_pkt_cnt),        64'd0);
        chk({tag, "_err_cnt"},  64'(out_err_cnt),        64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready),           64'd1);
    endtask

    initial begin
        int h1, h2, hx;
        int kind;

        // Power-on reset.
        idle(3);
        rst = 1'b1;
        #0;
        check_reset_state("por");

        // Nominal packet: flow 5, length 3, three words back-to-back.
        send_pkt(13'd5, 9'd3, 3, hx);
        compare_all("nominal");

        // Two length-1 packets offered back-to-back: arrivals exactly GAP apart.
        send_pkt(13'd1, 9'd1, 1, h1);
        send_pkt(13'd2, 9'd1, 1, h2);
        chk("gap_hdr_spacing", 64'(h2 - h1), 64'(GAP));
        compare_all("gap");

        // Short packet: length 4 with eop on the second word.
        send_pkt(13'd9, 9'd4, 2, hx);
        compare_all("short");

        // Long packet: length 2 with five words, then a normal packet.
        send_pkt(13'd10, 9'd2, 5, hx);
        send_pkt(13'd11, 9'd1, 1, hx);
        compare_all("long");

        // Stray data word in IDLE and a zero-length header.
        send_stray();
        send_pkt(13'd3, 9'd0, 0, hx);
        compare_all("errors");

        // Randomized mix of good, short, long, stray and empty packets.
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      send_stray();
            else if (kind == 1) send_pkt(13'($urandom), 9'd0, 0, hx);
            else                send_pkt(13'($urandom), 9'($urandom_range(1, 6)),
                                         $urandom_range(1, 8), hx);
            idle($urandom_range(0, 3));
        end
        compare_all("random");

        // Reset after one word of a three-word packet.
        send_word(1'b1, 1'b0, make_hdr(13'd7, 9'd3));
        send_word(1'b0, 1'b0, {$urandom, $urandom});
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        got_arr.delete();
        got_dat.delete();
        exp_pkt = 0;
        exp_err = 0;
        check_reset_state("midpkt_reset");
        send_pkt(13'd6, 9'd3, 3, hx);
        compare_all("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
